// File: rtl/vx_mp_scoreboard_if.sv
// Issue/writeback bundle for vx_mp_scoreboard: the master drives issue and
// writeback requests, the slave (scoreboard) returns ready, busy and status.
interface vx_mp_scoreboard_if #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_REGS      = 64,
    parameter int NUM_WB_PORTS  = 2,
    parameter int PERF_CTR_BITS = 44
) ();
    localparam int WIDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int RB   = $clog2(NUM_REGS);

    logic                          issue_valid;
    logic [WIDW-1:0]               issue_wid;
    logic                          issue_wb;
    logic [RB-1:0]                 issue_rd;
    logic [RB-1:0]                 issue_rs1;
    logic [RB-1:0]                 issue_rs2;
    logic [RB-1:0]                 issue_rs3;
    logic                          issue_ready;

    logic [NUM_WB_PORTS-1:0]       wb_valid;
    logic [NUM_WB_PORTS*WIDW-1:0]  wb_wid;
    logic [NUM_WB_PORTS*RB-1:0]    wb_rd;
    logic [NUM_WB_PORTS-1:0]       wb_eop;

    logic [NUM_WARPS-1:0]          warp_busy;
    logic                          release_err;
    logic [PERF_CTR_BITS-1:0]      perf_stalls;

    modport master (
        output issue_valid, issue_wid, issue_wb, issue_rd, issue_rs1, issue_rs2, issue_rs3,
        output wb_valid, wb_wid, wb_rd, wb_eop,
        input  issue_ready, warp_busy, release_err, perf_stalls
    );

    modport slave (
        input  issue_valid, issue_wid, issue_wb, issue_rd, issue_rs1, issue_rs2, issue_rs3,
        input  wb_valid, wb_wid, wb_rd, wb_eop,
        output issue_ready, warp_busy, release_err, perf_stalls
    );
endinterface

// File: rtl/vx_mp_scoreboard.sv
// Multi-port per-warp register scoreboard with same-cycle writeback bypass.
// Optional stall counter enabled by defining SCOREBOARD_PERF_EN.
module vx_mp_scoreboard #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_REGS      = 64,
    parameter int NUM_WB_PORTS  = 2,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic               clk,
    input  logic               reset,
    vx_mp_scoreboard_if.slave  sb
);
    localparam int WIDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int RB   = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0] r_pending [NUM_WARPS];
    logic                r_release_err;

    logic [NUM_REGS-1:0] w_release [NUM_WARPS];
    logic [NUM_REGS-1:0] w_next    [NUM_WARPS];
    logic [NUM_REGS-1:0] w_sel_busy;
    logic                w_fire;
    logic                w_rel_err;

    // x0 is never reserved, so its writebacks are ignored rather than flagged
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_release[w] = '0;
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (sb.wb_valid[p] && sb.wb_eop[p] &&
                    sb.wb_wid[p*WIDW +: WIDW] == WIDW'(w) &&
                    sb.wb_rd[p*RB +: RB] != '0) begin
                    w_release[w][sb.wb_rd[p*RB +: RB]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_busy = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (sb.issue_wid == WIDW'(w)) begin
                w_sel_busy = r_pending[w] & ~w_release[w];
            end
        end
    end

    assign sb.issue_ready = ~(w_sel_busy[sb.issue_rs1] |
                              w_sel_busy[sb.issue_rs2] |
                              w_sel_busy[sb.issue_rs3] |
                              (sb.issue_wb & w_sel_busy[sb.issue_rd]));

    assign w_fire = sb.issue_valid & sb.issue_ready & sb.issue_wb & (sb.issue_rd != '0);

    // reserve is applied after the release so it wins on a collision
    always_comb begin
        w_rel_err = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_next[w] = r_pending[w] & ~w_release[w];
            if (w_fire && sb.issue_wid == WIDW'(w)) begin
                w_next[w][sb.issue_rd] = 1'b1;
            end
            w_next[w][0] = 1'b0;
            w_rel_err = w_rel_err | (|(w_release[w] & ~r_pending[w]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_pending[w] <= '0;
            end
            r_release_err <= 1'b0;
        end else begin
            r_pending     <= w_next;
            r_release_err <= r_release_err | w_rel_err;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            sb.warp_busy[w] = |r_pending[w];
        end
    end

    assign sb.release_err = r_release_err;

`ifdef SCOREBOARD_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_perf_stalls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stalls <= '0;
        end else if (sb.issue_valid && !sb.issue_ready && !(&r_perf_stalls)) begin
            r_perf_stalls <= r_perf_stalls + 1'b1;
        end
    end

    assign sb.perf_stalls = r_perf_stalls;
`else
    assign sb.perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vx_mp_scoreboard.sv
// Self-checking bench for vx_mp_scoreboard: directed scenarios plus random
// issue/writeback traffic against a set-of-pending-registers model.
module tb_vx_mp_scoreboard;
    localparam int NW   = 4;
    localparam int NR   = 64;
    localparam int NP   = 2;
    localparam int PB   = 4;
    localparam int WIDW = 2;
    localparam int RB   = 6;
`ifdef SCOREBOARD_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif
    localparam int PERF_MAX = (1 << PB) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_mp_scoreboard_if #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_WB_PORTS(NP), .PERF_CTR_BITS(PB)) sb_if ();

    vx_mp_scoreboard #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_WB_PORTS(NP), .PERF_CTR_BITS(PB)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    int vectors = 0;
    int miscompares = 0;

    bit m_pend [NW][NR];
    bit m_err;
    int m_perf;

    function automatic bit m_released(int w, int r);
        bit rel = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (sb_if.wb_valid[p] && sb_if.wb_eop[p] &&
                int'(sb_if.wb_wid[p*WIDW +: WIDW]) == w && int'(sb_if.wb_rd[p*RB +: RB]) == r)
                rel = 1'b1;
        end
        return rel;
    endfunction

    function automatic bit m_busy(int w, int r);
        return (r != 0) && m_pend[w][r] && !m_released(w, r);
    endfunction

    function automatic bit m_ready();
        int w = int'(sb_if.issue_wid);
        bit hz;
        hz = m_busy(w, int'(sb_if.issue_rs1)) || m_busy(w, int'(sb_if.issue_rs2)) ||
             m_busy(w, int'(sb_if.issue_rs3)) || (sb_if.issue_wb && m_busy(w, int'(sb_if.issue_rd)));
        return !hz;
    endfunction

    function automatic logic [NW-1:0] m_warp_busy();
        logic [NW-1:0] v = '0;
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                if (m_pend[w][r]) v[w] = 1'b1;
        return v;
    endfunction

    task automatic m_clear();
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                m_pend[w][r] = 1'b0;
        m_err  = 1'b0;
        m_perf = 0;
    endtask

    task automatic set_issue(bit v, int wid, bit wb, int rd, int rs1, int rs2, int rs3);
        sb_if.issue_valid = v;
        sb_if.issue_wid   = WIDW'(wid);
        sb_if.issue_wb    = wb;
        sb_if.issue_rd    = RB'(rd);
        sb_if.issue_rs1   = RB'(rs1);
        sb_if.issue_rs2   = RB'(rs2);
        sb_if.issue_rs3   = RB'(rs3);
    endtask

    task automatic set_wb(int p, bit v, int wid, int rd, bit eop);
        sb_if.wb_valid[p]            = v;
        sb_if.wb_wid[p*WIDW +: WIDW] = WIDW'(wid);
        sb_if.wb_rd[p*RB +: RB]      = RB'(rd);
        sb_if.wb_eop[p]              = eop;
    endtask

    task automatic clear_wb();
        sb_if.wb_valid = '0;
        sb_if.wb_wid   = '0;
        sb_if.wb_rd    = '0;
        sb_if.wb_eop   = '0;
    endtask

    // Advance one clock from the current inputs and update the model to match.
    task automatic tick();
        bit clr [NW][NR] = '{default: 1'b0};
        bit rdy, fire, nerr;
        int fw, fr;
        rdy  = m_ready();
        nerr = m_err;
        for (int p = 0; p < NP; p++) begin
            if (sb_if.wb_valid[p] && sb_if.wb_eop[p]) begin
                int w = int'(sb_if.wb_wid[p*WIDW +: WIDW]);
                int r = int'(sb_if.wb_rd[p*RB +: RB]);
                if (r != 0) begin
                    if (!m_pend[w][r]) nerr = 1'b1;
                    clr[w][r] = 1'b1;
                end
            end
        end
        fw   = int'(sb_if.issue_wid);
        fr   = int'(sb_if.issue_rd);
        fire = sb_if.issue_valid && rdy && sb_if.issue_wb && fr != 0;
        if (PERF_EN && sb_if.issue_valid && !rdy && m_perf < PERF_MAX) m_perf++;
        @(posedge clk);
        #1;
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                if (clr[w][r]) m_pend[w][r] = 1'b0;
        if (fire) m_pend[fw][fr] = 1'b1;
        m_err = nerr;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        m_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        clear_wb();
        reset = 1'b1;
        #1;
        m_clear();
        vectors++;
        if (sb_if.issue_ready !== 1'b1 || sb_if.warp_busy !== 4'b0000 ||
            sb_if.release_err !== 1'b0 || sb_if.perf_stalls !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b busy=%b err=%b perf=%0d expected 1 0000 0 0",
                     sb_if.issue_ready, sb_if.warp_busy, sb_if.release_err, sb_if.perf_stalls);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_reserve();
        set_issue(1, 1, 1, 7, 5, 0, 0);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL first_issue_ready: got %b expected 1", sb_if.issue_ready);
        end
        tick();
        vectors++;
        if (sb_if.warp_busy !== 4'b0010) begin
            miscompares++;
            $display("FAIL warp_busy_after_reserve: got %b expected 0010", sb_if.warp_busy);
        end
        set_issue(1, 1, 0, 0, 0, 7, 0);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_same_warp: got %b expected 0", sb_if.issue_ready);
        end
        set_issue(1, 0, 0, 0, 0, 7, 0);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL other_warp_isolated: got %b expected 1", sb_if.issue_ready);
        end
        tick();
    endtask

    task automatic test_bypass();
        set_issue(1, 2, 1, 9, 0, 0, 0);
        tick();
        set_issue(1, 2, 0, 0, 9, 0, 0);
        set_wb(1, 1, 2, 9, 0);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL no_eop_no_bypass: got %b expected 0", sb_if.issue_ready);
        end
        tick();
        vectors++;
        if (sb_if.issue_ready !== 1'b0 || sb_if.warp_busy[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL no_eop_bit_kept: got rdy=%b busy2=%b expected 0 1",
                     sb_if.issue_ready, sb_if.warp_busy[2]);
        end
        set_wb(1, 1, 2, 9, 1);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL eop_bypass: got %b expected 1", sb_if.issue_ready);
        end
        tick();
        clear_wb();
        #1;
        vectors++;
        if (sb_if.warp_busy[2] !== 1'b0 || sb_if.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL released_clear: got busy2=%b rdy=%b expected 0 1",
                     sb_if.warp_busy[2], sb_if.issue_ready);
        end
    endtask

    task automatic test_reserve_wins();
        set_issue(1, 0, 1, 3, 0, 0, 0);
        tick();
        set_wb(0, 1, 0, 3, 1);
        set_issue(1, 0, 1, 3, 0, 0, 0);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_bypass_ready: got %b expected 1", sb_if.issue_ready);
        end
        tick();
        clear_wb();
        set_issue(1, 0, 0, 0, 3, 0, 0);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b0 || sb_if.warp_busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reserve_wins: got rdy=%b busy0=%b expected 0 1",
                     sb_if.issue_ready, sb_if.warp_busy[0]);
        end
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 1, 0, 3, 1);
        tick();
        clear_wb();
        vectors++;
        if (sb_if.release_err !== 1'b0 || sb_if.warp_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_release: got err=%b busy0=%b expected 0 0",
                     sb_if.release_err, sb_if.warp_busy[0]);
        end
    endtask

    task automatic test_x0_and_err();
        set_issue(1, 3, 1, 0, 0, 0, 0);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_issue_ready: got %b expected 1", sb_if.issue_ready);
        end
        tick();
        vectors++;
        if (sb_if.warp_busy[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_not_reserved: got busy3=%b expected 0", sb_if.warp_busy[3]);
        end
        set_issue(1, 3, 1, 0, 0, 0, 0);
        #1;
        vectors++;
        if (sb_if.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_read_never_stalls: got %b expected 1", sb_if.issue_ready);
        end
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 1, 3, 12, 1);
        tick();
        clear_wb();
        vectors++;
        if (sb_if.release_err !== 1'b1) begin
            miscompares++;
            $display("FAIL release_err_set: got %b expected 1", sb_if.release_err);
        end
        repeat (3) tick();
        vectors++;
        if (sb_if.release_err !== 1'b1) begin
            miscompares++;
            $display("FAIL release_err_sticky: got %b expected 1", sb_if.release_err);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            set_issue($urandom_range(0, 1) == 1, int'($urandom_range(0, NW-1)), $urandom_range(0, 1) == 1,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            for (int p = 0; p < NP; p++)
                set_wb(p, $urandom_range(0, 1) == 1, int'($urandom_range(0, NW-1)),
                       int'($urandom_range(1, 7)), $urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (sb_if.issue_ready !== m_ready()) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", i, sb_if.issue_ready, m_ready());
            end
            tick();
            vectors++;
            if (sb_if.warp_busy !== m_warp_busy() || sb_if.release_err !== m_err ||
                sb_if.perf_stalls !== PB'(m_perf)) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got busy=%b err=%b perf=%0d expected %b %b %0d",
                         i, sb_if.warp_busy, sb_if.release_err, sb_if.perf_stalls,
                         m_warp_busy(), m_err, m_perf);
            end
        end
        clear_wb();
    endtask

    task automatic test_perf_and_async_reset();
        apply_reset();
        set_issue(1, 1, 1, 20, 0, 0, 0);
        tick();
        set_issue(1, 1, 0, 0, 20, 0, 0);
        repeat (5) tick();
        vectors++;
        if (sb_if.perf_stalls !== (PERF_EN ? 4'd5 : 4'd0)) begin
            miscompares++;
            $display("FAIL perf_count_5: got %0d expected %0d", sb_if.perf_stalls, PERF_EN ? 5 : 0);
        end
        repeat (15) tick();
        vectors++;
        if (sb_if.perf_stalls !== (PERF_EN ? 4'd15 : 4'd0)) begin
            miscompares++;
            $display("FAIL perf_saturate: got %0d expected %0d", sb_if.perf_stalls, PERF_EN ? 15 : 0);
        end
        #2;
        reset = 1'b1;
        #1;
        m_clear();
        vectors++;
        if (sb_if.perf_stalls !== 4'd0 || sb_if.warp_busy !== 4'b0000 || sb_if.issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got perf=%0d busy=%b rdy=%b expected 0 0000 1",
                     sb_if.perf_stalls, sb_if.warp_busy, sb_if.issue_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 1, 1, 20, 1);
        tick();
        clear_wb();
        vectors++;
        if (sb_if.release_err !== 1'b1) begin
            miscompares++;
            $display("FAIL release_after_reset: got %b expected 1", sb_if.release_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic_reserve();
        test_bypass();
        test_reserve_wins();
        test_x0_and_err();
        test_random();
        test_perf_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
